// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared command encodings, arbiter state and owner types
package mem_arb_pkg;

    typedef logic [1:0] mem_cmd_t;

    // Same encoding the CPU state machine drives on its memory command outputs.
    localparam mem_cmd_t MEM_NONE = 2'b00;
    localparam mem_cmd_t MEM_WR   = 2'b01;
    localparam mem_cmd_t MEM_RD   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DMA = 1'b1
    } owner_t;

    function automatic logic cmd_legal(input mem_cmd_t cmd);
        return (cmd == MEM_WR) || (cmd == MEM_RD);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, RAM and status signals of the two-port memory arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    mem_cmd_t          cpu_cmd;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              dma_req;
    mem_cmd_t          dma_cmd;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_err;

    mem_cmd_t          mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;
    logic              busy;

    modport master (
        input  cpu_req, cpu_cmd, cpu_addr, cpu_wdata,
        input  dma_req, dma_cmd, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, cpu_err,
        output dma_ack, dma_rdata, dma_err,
        output mem_cmd, mem_addr, mem_wdata,
        output owner, busy
    );

    modport slave (
        output cpu_req, cpu_cmd, cpu_addr, cpu_wdata,
        output dma_req, dma_cmd, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_err,
        input  dma_ack, dma_rdata, dma_err,
        input  mem_cmd, mem_addr, mem_wdata,
        input  owner, busy
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/DMA arbiter sequencing one RAM port with fixed read latency
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    arb_state_t        state;
    owner_t            owner_q;
    owner_t            grant;
    logic              grant_valid;
    mem_cmd_t          cmd_q;
    mem_cmd_t          sel_cmd;
    mem_cmd_t          mem_cmd_q;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic [1:0]        cnt;
    logic              cpu_ack_q;
    logic              dma_ack_q;
    logic              cpu_err_q;
    logic              dma_err_q;

    // On contention the requester that did not hold the last grant wins.
    always_comb begin
        grant_valid = bus.cpu_req | bus.dma_req;
        if (bus.cpu_req && bus.dma_req) begin
            grant = (owner_q == CPU) ? DMA : CPU;
        end else begin
            grant = bus.dma_req ? DMA : CPU;
        end
        sel_cmd   = (grant == DMA) ? bus.dma_cmd   : bus.cpu_cmd;
        sel_addr  = (grant == DMA) ? bus.dma_addr  : bus.cpu_addr;
        sel_wdata = (grant == DMA) ? bus.dma_wdata : bus.cpu_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner_q     <= DMA;
            cmd_q       <= MEM_NONE;
            mem_cmd_q   <= MEM_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cnt         <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_err_q   <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            cpu_err_q <= 1'b0;
            dma_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q     <= grant;
                        cmd_q       <= sel_cmd;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        if (cmd_legal(sel_cmd)) begin
                            mem_cmd_q <= sel_cmd;
                            state     <= ISSUE;
                        end else begin
                            // Illegal command completes without touching the RAM.
                            cpu_ack_q <= (grant == CPU);
                            dma_ack_q <= (grant == DMA);
                            cpu_err_q <= (grant == CPU);
                            dma_err_q <= (grant == DMA);
                            state     <= ACK;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_q == MEM_WR) begin
                        mem_cmd_q <= MEM_NONE;
                        cpu_ack_q <= (owner_q == CPU);
                        dma_ack_q <= (owner_q == DMA);
                        state     <= ACK;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        if (owner_q == CPU) begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end else begin
                            dma_rdata_q <= bus.mem_rdata;
                        end
                        mem_cmd_q <= MEM_NONE;
                        cpu_ack_q <= (owner_q == CPU);
                        dma_ack_q <= (owner_q == DMA);
                        state     <= ACK;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_err   = dma_err_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.mem_cmd   = mem_cmd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with read latencies 1 and 3
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(9), .DATA_W(16)) if1 ();
    mem_arbiter_if #(.ADDR_W(9), .DATA_W(16)) if3 ();

    mem_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    mem_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    // RAM models: read data appears RD_LAT cycles after the issue cycle.
    logic [15:0] ram1 [0:511];
    logic [15:0] pipe1;
    always @(posedge clk) begin
        if (if1.mem_cmd == 2'b01) ram1[if1.mem_addr] <= if1.mem_wdata;
        if (if1.mem_cmd == 2'b10) pipe1 <= ram1[if1.mem_addr];
    end
    assign if1.mem_rdata = pipe1;

    logic [15:0] ram3 [0:511];
    logic [15:0] pipe3 [0:2];
    always @(posedge clk) begin
        if (if3.mem_cmd == 2'b01) ram3[if3.mem_addr] <= if3.mem_wdata;
        if (if3.mem_cmd == 2'b10) pipe3[0] <= ram3[if3.mem_addr];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign if3.mem_rdata = pipe3[2];

    typedef struct {
        logic        port;
        int          cyc;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (if1.mem_cmd !== 2'b00) begin errors++; $display("FAIL rst_mem_cmd got=%b exp=00", if1.mem_cmd); end
        checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", if1.busy); end
        checks++; if ({if1.cpu_ack, if1.dma_ack, if1.cpu_err, if1.dma_err} !== 4'b0000) begin
            errors++; $display("FAIL rst_ack_err got=%b exp=0000", {if1.cpu_ack, if1.dma_ack, if1.cpu_err, if1.dma_err}); end
        checks++; if (if1.owner !== 1'b1) begin errors++; $display("FAIL rst_owner got=%b exp=1", if1.owner); end
        checks++; if (if3.owner !== 1'b1) begin errors++; $display("FAIL rst_owner3 got=%b exp=1", if3.owner); end
        checks++; if ({if1.cpu_rdata, if1.dma_rdata, if1.mem_addr} !== '0) begin
            errors++; $display("FAIL rst_data got=%h/%h/%h exp=0", if1.cpu_rdata, if1.dma_rdata, if1.mem_addr); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_cpu_write();
        exp_t e;
        logic drop = 1'b0;
        @(posedge clk); #1;
        if1.cpu_cmd = 2'b01; if1.cpu_addr = 9'h005; if1.cpu_wdata = 16'hABCD; if1.cpu_req = 1'b1;
        sb.push_back('{port: 1'b0, cyc: 2, err: 1'b0, rdata: 16'h0});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (if1.mem_cmd !== ((c == 1) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL wr_mem_cmd cyc=%0d got=%b exp=%b", c, if1.mem_cmd, (c == 1) ? 2'b01 : 2'b00); end
            checks++; if (if1.dma_ack !== 1'b0) begin errors++; $display("FAIL wr_dma_ack cyc=%0d got=%b exp=0", c, if1.dma_ack); end
            if (c == 1) begin
                checks++; if ({if1.mem_addr, if1.mem_wdata} !== {9'h005, 16'hABCD}) begin
                    errors++; $display("FAIL wr_mem_bus got=%h/%h exp=005/abcd", if1.mem_addr, if1.mem_wdata); end
            end
            if (if1.cpu_ack || if1.dma_ack) begin
                drop = 1'b1;
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL wr_extra_ack cyc=%0d got=ack exp=none", c); end
                else begin
                    e = sb.pop_front();
                    checks++; if ({if1.dma_ack, if1.cpu_ack} !== (e.port ? 2'b10 : 2'b01) || c !== e.cyc) begin
                        errors++; $display("FAIL wr_ack got=%b@%0d exp=port%0d@%0d", {if1.dma_ack, if1.cpu_ack}, c, e.port, e.cyc); end
                    checks++; if ((if1.cpu_err | if1.dma_err) !== e.err) begin
                        errors++; $display("FAIL wr_err got=%b exp=%b", if1.cpu_err | if1.dma_err, e.err); end
                end
            end
            @(posedge clk); #1;
            if (drop) if1.cpu_req = 1'b0;
        end
        if1.cpu_req = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wr_missing_ack got=%0d pending exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_dma_read();
        exp_t e;
        logic drop = 1'b0;
        @(posedge clk); #1;
        if1.dma_cmd = 2'b10; if1.dma_addr = 9'h005; if1.dma_req = 1'b1;
        sb.push_back('{port: 1'b1, cyc: 3, err: 1'b0, rdata: 16'hABCD});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (if1.mem_cmd !== ((c == 1 || c == 2) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL rd_mem_cmd cyc=%0d got=%b exp=%b", c, if1.mem_cmd, (c == 1 || c == 2) ? 2'b10 : 2'b00); end
            checks++; if (if1.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_cpu_ack cyc=%0d got=%b exp=0", c, if1.cpu_ack); end
            if (if1.cpu_ack || if1.dma_ack) begin
                drop = 1'b1;
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rd_extra_ack cyc=%0d got=ack exp=none", c); end
                else begin
                    e = sb.pop_front();
                    checks++; if ({if1.dma_ack, if1.cpu_ack} !== (e.port ? 2'b10 : 2'b01) || c !== e.cyc) begin
                        errors++; $display("FAIL rd_ack got=%b@%0d exp=port%0d@%0d", {if1.dma_ack, if1.cpu_ack}, c, e.port, e.cyc); end
                    checks++; if (if1.dma_rdata !== e.rdata) begin
                        errors++; $display("FAIL rd_rdata got=%h exp=%h", if1.dma_rdata, e.rdata); end
                    checks++; if (if1.owner !== e.port) begin errors++; $display("FAIL rd_owner got=%b exp=%b", if1.owner, e.port); end
                end
            end
            @(posedge clk); #1;
            if (drop) if1.dma_req = 1'b0;
        end
        if1.dma_req = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rd_missing_ack got=%0d pending exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_illegal();
        exp_t e;
        logic drop = 1'b0;
        @(posedge clk); #1;
        if1.cpu_cmd = 2'b11; if1.cpu_addr = 9'h0AA; if1.cpu_req = 1'b1;
        sb.push_back('{port: 1'b0, cyc: 1, err: 1'b1, rdata: 16'h0});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (if1.mem_cmd !== 2'b00) begin errors++; $display("FAIL ill_mem_cmd cyc=%0d got=%b exp=00", c, if1.mem_cmd); end
            if (if1.cpu_ack || if1.dma_ack) begin
                drop = 1'b1;
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL ill_extra_ack cyc=%0d got=ack exp=none", c); end
                else begin
                    e = sb.pop_front();
                    checks++; if ({if1.dma_ack, if1.cpu_ack} !== (e.port ? 2'b10 : 2'b01) || c !== e.cyc) begin
                        errors++; $display("FAIL ill_ack got=%b@%0d exp=port%0d@%0d", {if1.dma_ack, if1.cpu_ack}, c, e.port, e.cyc); end
                    checks++; if ({if1.dma_err, if1.cpu_err} !== {1'b0, e.err}) begin
                        errors++; $display("FAIL ill_err got=%b exp=0%b", {if1.dma_err, if1.cpu_err}, e.err); end
                end
            end
            @(posedge clk); #1;
            if (drop) if1.cpu_req = 1'b0;
        end
        if1.cpu_req = 1'b0;
        if1.cpu_cmd = 2'b00;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ill_missing_ack got=%0d pending exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int acks = 0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        if1.cpu_cmd = 2'b01; if1.cpu_addr = 9'h010; if1.cpu_wdata = 16'h1111;
        if1.dma_cmd = 2'b01; if1.dma_addr = 9'h020; if1.dma_wdata = 16'h2222;
        if1.cpu_req = 1'b1; if1.dma_req = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back('{port: k[0], cyc: 2 + 3 * k, err: 1'b0, rdata: 16'h0});
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (if1.cpu_ack || if1.dma_ack) begin
                acks++;
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rr_extra_ack cyc=%0d got=ack exp=none", c); end
                else begin
                    e = sb.pop_front();
                    checks++; if ({if1.dma_ack, if1.cpu_ack} !== (e.port ? 2'b10 : 2'b01) || c !== e.cyc) begin
                        errors++; $display("FAIL rr_ack got=%b@%0d exp=port%0d@%0d", {if1.dma_ack, if1.cpu_ack}, c, e.port, e.cyc); end
                    checks++; if (if1.owner !== e.port) begin errors++; $display("FAIL rr_owner cyc=%0d got=%b exp=%b", c, if1.owner, e.port); end
                end
            end
            @(posedge clk); #1;
            if (acks >= 4) begin if1.cpu_req = 1'b0; if1.dma_req = 1'b0; end
        end
        if1.cpu_req = 1'b0; if1.dma_req = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rr_missing_ack got=%0d pending exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        logic drop = 1'b0;
        @(posedge clk); #1;
        if1.dma_cmd = 2'b10; if1.dma_addr = 9'h005; if1.dma_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({if1.mem_cmd, if1.busy} !== 3'b101) begin
            errors++; $display("FAIL rw_wait_state got=%b/%b exp=10/1", if1.mem_cmd, if1.busy); end
        #1; reset = 1'b0; if1.dma_req = 1'b0;
        #1;
        checks++; if ({if1.mem_cmd, if1.busy, if1.dma_ack, if1.cpu_ack} !== 5'b00000) begin
            errors++; $display("FAIL rw_async_clear got=%b exp=00000", {if1.mem_cmd, if1.busy, if1.dma_ack, if1.cpu_ack}); end
        checks++; if ({if1.owner, if1.dma_rdata} !== {1'b1, 16'h0}) begin
            errors++; $display("FAIL rw_async_regs got=%b/%h exp=1/0000", if1.owner, if1.dma_rdata); end
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (if1.dma_ack !== 1'b0) begin errors++; $display("FAIL rw_stale_ack cyc=%0d got=%b exp=0", c, if1.dma_ack); end
        end
        @(posedge clk); #1;
        if1.cpu_cmd = 2'b01; if1.cpu_addr = 9'h030; if1.cpu_wdata = 16'h3333;
        if1.dma_cmd = 2'b01; if1.dma_addr = 9'h031; if1.dma_wdata = 16'h4444;
        if1.cpu_req = 1'b1; if1.dma_req = 1'b1;
        sb.push_back('{port: 1'b0, cyc: 2, err: 1'b0, rdata: 16'h0});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (if1.cpu_ack || if1.dma_ack) begin
                drop = 1'b1;
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rw_extra_ack cyc=%0d got=ack exp=none", c); end
                else begin
                    e = sb.pop_front();
                    checks++; if ({if1.dma_ack, if1.cpu_ack} !== (e.port ? 2'b10 : 2'b01) || c !== e.cyc) begin
                        errors++; $display("FAIL rw_first_grant got=%b@%0d exp=port%0d@%0d", {if1.dma_ack, if1.cpu_ack}, c, e.port, e.cyc); end
                end
            end
            @(posedge clk); #1;
            if (drop) begin if1.cpu_req = 1'b0; if1.dma_req = 1'b0; end
        end
        if1.cpu_req = 1'b0; if1.dma_req = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rw_missing_ack got=%0d pending exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_lat3();
        exp_t e;
        logic drop = 1'b0;
        @(posedge clk); #1;
        if3.cpu_cmd = 2'b01; if3.cpu_addr = 9'h007; if3.cpu_wdata = 16'h5A5A; if3.cpu_req = 1'b1;
        sb.push_back('{port: 1'b0, cyc: 2, err: 1'b0, rdata: 16'h0});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (if3.cpu_ack || if3.dma_ack) begin
                drop = 1'b1;
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL l3w_extra_ack cyc=%0d got=ack exp=none", c); end
                else begin
                    e = sb.pop_front();
                    checks++; if ({if3.dma_ack, if3.cpu_ack} !== (e.port ? 2'b10 : 2'b01) || c !== e.cyc) begin
                        errors++; $display("FAIL l3w_ack got=%b@%0d exp=port%0d@%0d", {if3.dma_ack, if3.cpu_ack}, c, e.port, e.cyc); end
                end
            end
            @(posedge clk); #1;
            if (drop) if3.cpu_req = 1'b0;
        end
        if3.cpu_req = 1'b0;
        @(posedge clk); #1;
        if3.cpu_cmd = 2'b10; if3.cpu_addr = 9'h007; if3.cpu_req = 1'b1;
        sb.push_back('{port: 1'b0, cyc: 5, err: 1'b0, rdata: 16'h5A5A});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (if3.mem_cmd !== ((c >= 1 && c <= 4) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL l3_mem_cmd cyc=%0d got=%b exp=%b", c, if3.mem_cmd, (c >= 1 && c <= 4) ? 2'b10 : 2'b00); end
            if (c == 6) begin
                checks++; if (if3.busy !== 1'b0) begin errors++; $display("FAIL l3_idle got=busy%b exp=busy0", if3.busy); end
            end
            if (if3.cpu_ack || if3.dma_ack) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL l3_extra_ack cyc=%0d got=ack exp=none", c); end
                else begin
                    e = sb.pop_front();
                    checks++; if ({if3.dma_ack, if3.cpu_ack} !== (e.port ? 2'b10 : 2'b01) || c !== e.cyc) begin
                        errors++; $display("FAIL l3_ack got=%b@%0d exp=port%0d@%0d", {if3.dma_ack, if3.cpu_ack}, c, e.port, e.cyc); end
                    checks++; if (if3.cpu_rdata !== e.rdata) begin
                        errors++; $display("FAIL l3_rdata got=%h exp=%h", if3.cpu_rdata, e.rdata); end
                end
            end
            @(posedge clk); #1;
            if (c == 1) if3.cpu_req = 1'b0;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL l3_missing_ack got=%0d pending exp=0", sb.size()); sb.delete(); end
    endtask

    initial begin
        if1.cpu_req = 1'b0; if1.cpu_cmd = 2'b00; if1.cpu_addr = '0; if1.cpu_wdata = '0;
        if1.dma_req = 1'b0; if1.dma_cmd = 2'b00; if1.dma_addr = '0; if1.dma_wdata = '0;
        if3.cpu_req = 1'b0; if3.cpu_cmd = 2'b00; if3.cpu_addr = '0; if3.cpu_wdata = '0;
        if3.dma_req = 1'b0; if3.dma_cmd = 2'b00; if3.dma_addr = '0; if3.dma_wdata = '0;
        test_reset();
        test_cpu_write();
        test_dma_read();
        test_illegal();
        test_round_robin();
        test_reset_in_wait();
        test_lat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
